apb_timer_mm: RTL and testbench

APB_TIMER_MM -- requirements
Module: apb_timer_mm

---
 rtl/apb_timer_mm.sv | 124 ++++++++++++
 tb/tb_apb_timer_mm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_mm.sv
// apb_timer_mm: APB-mapped timer with prescaler/external tick, up/down/up-down counting and flag interrupts
// Ports:
//   pclk, preset              clock and synchronous active-high reset
//   psel, penable, pwrite     APB control
//   paddr, pwdata             APB byte address (only [3:0] decoded) and write data
//   prdata, pready, pslverr   APB read data, ready (always 1), error
//   ext_in                    asynchronous external tick source
//   irq                       registered level interrupt
module apb_timer_mm #(
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  ext_in,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  irq
);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    logic [8:0] tcr_q, tcr_d;
    logic [1:0] tsr_q, tsr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, min_q, min_d, max_q, max_d;
    logic [6:0] pre_q, pre_d, mask;
    logic [2:0] sync_q, sync_d;
    logic dir_q, dir_d, irq_q, irq_d;
    logic [31:0] wd, rd;
    logic [3:0] off;
    logic [1:0] mode;
    logic acc, err, wr_ok, pre_tick, ext_tick, step, up_dir, dn_dir, ovf_set, unf_set;
    logic unused;
    always_comb begin
        wd = 32'(pwdata);
        off = paddr[3:0];
        mode = tcr_q[2:1];
        acc = psel & penable;
        // mode=11 is rejected at the bus so it can never reach the counter
        err = acc & ((off > 4'd4) | (pwrite & (off == 4'd0) & (wd[2:1] == 2'b11)));
        wr_ok = acc & pwrite & ~err;
        // prescaler wraps at 2^div_sel-1: mask has div_sel low bits set
        mask = ~(7'h7f << tcr_q[5:3]);
        pre_tick = pre_q == mask;
        ext_tick = sync_q[1] & ~sync_q[2];
        step = tcr_q[0] & (tcr_q[6] ? ext_tick : pre_tick);
        sync_d = {sync_q[1:0], ext_in};
        pre_d = (~tcr_q[0] | pre_tick | (wr_ok & (off == 4'd0))) ? 7'd0 : pre_q + 7'd1;
        up_dir = (mode == 2'b00) | ((mode == 2'b10) & ~dir_q);
        dn_dir = (mode == 2'b01) | ((mode == 2'b10) & dir_q);
        cnt_d = cnt_q;
        dir_d = dir_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (step) begin
            if (min_q >= max_q) begin
                cnt_d = min_q;
                dir_d = 1'b0;
            end else if (up_dir) begin
                if (cnt_q >= max_q) begin
                    cnt_d = (mode == 2'b10) ? max_q - ONE : min_q;
                    dir_d = mode == 2'b10;
                    ovf_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else if (dn_dir) begin
                if (cnt_q <= min_q) begin
                    cnt_d = (mode == 2'b10) ? min_q + ONE : max_q;
                    dir_d = 1'b0;
                    unf_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
        if (wr_ok & (off == 4'd2)) cnt_d = wd[CNT_WIDTH-1:0];
        if (wr_ok & (off == 4'd0)) dir_d = 1'b0;
        tcr_d = (wr_ok & (off == 4'd0)) ? wd[8:0] : tcr_q;
        min_d = (wr_ok & (off == 4'd3)) ? wd[CNT_WIDTH-1:0] : min_q;
        max_d = (wr_ok & (off == 4'd4)) ? wd[CNT_WIDTH-1:0] : max_q;
        // flag set wins over a same-cycle clear-write
        tsr_d = ((wr_ok & (off == 4'd1)) ? tsr_q & wd[1:0] : tsr_q) | {unf_set, ovf_set};
        irq_d = (tsr_q[0] & tcr_q[7]) | (tsr_q[1] & tcr_q[8]);
        rd = (off == 4'd0) ? 32'(tcr_q) :
             (off == 4'd1) ? 32'(tsr_q) :
             (off == 4'd2) ? 32'(cnt_q) :
             (off == 4'd3) ? 32'(min_q) :
             (off == 4'd4) ? 32'(max_q) : 32'd0;
        prdata = (acc & ~pwrite) ? DATA_WIDTH'(rd) : '0;
        pready = 1'b1;
        pslverr = err;
        irq = irq_q;
        unused = ^{paddr, wd};
    end
    always_ff @(posedge pclk) begin
        if (preset) begin
            tcr_q <= '0;
            tsr_q <= '0;
            cnt_q <= '0;
            min_q <= '0;
            max_q <= '1;
            pre_q <= '0;
            sync_q <= '0;
            dir_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            tcr_q <= tcr_d;
            tsr_q <= tsr_d;
            cnt_q <= cnt_d;
            min_q <= min_d;
            max_q <= max_d;
            pre_q <= pre_d;
            sync_q <= sync_d;
            dir_q <= dir_d;
            irq_q <= irq_d;
        end
    end
endmodule

// File: tb/tb_apb_timer_mm.sv
// tb_apb_timer_mm: directed self-checking bench for apb_timer_mm
module tb_apb_timer_mm;
    logic pclk = 1'b0, preset = 1'b1, psel = 1'b0, penable = 1'b0, pwrite = 1'b0, ext_in = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic pready, pslverr, irq;
    int checks = 0, errors = 0;
    logic [31:0] d;
    logic er, irq_acc;
    logic [31:0] ud_cnt [5] = '{32'h3, 32'h4, 32'h3, 32'h2, 32'h3};
    logic [31:0] ud_tsr [5] = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h3};

    apb_timer_mm dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .ext_in(ext_in), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .irq(irq)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // called just after an edge; commits at the second following edge
    task automatic wr(input logic [3:0] a, input logic [31:0] v, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {8'h0, a}; pwdata = v;
        @(posedge pclk); #1;
        penable = 1'b1; #1;
        e = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // data is sampled in the access cycle, i.e. after the first following edge
    task automatic rd(input logic [3:0] a, output logic [31:0] v, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {8'h0, a};
        @(posedge pclk); #1;
        penable = 1'b1; #1;
        v = prdata; e = pslverr; irq_acc = irq;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        logic e;
        rd(a, v, e);
        chk(tag, v, exp);
    endtask

    // holds an access-phase read without advancing the clock
    task automatic peek(input logic [3:0] a, output logic [31:0] v);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = {8'h0, a};
        #1 v = prdata;
    endtask

    task automatic idle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        chk("rst_irq", irq, 0);
        chk("rst_pready", pready, 1);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_prdata_idle", prdata, 0);
        rchk("rst_tcr", 4'h0, 32'h0);
        rchk("rst_tsr", 4'h1, 32'h0);
        rchk("rst_cnt", 4'h2, 32'h0);
        rchk("rst_min", 4'h3, 32'h0);
        rd(4'h4, d, er);
        chk("rst_max", d, 32'hFFFF);
        chk("rd_ok_err", er, 0);
        // up mode, div_sel=3
        wr(4'h3, 32'h10, er);
        wr(4'h4, 32'h20, er);
        wr(4'h2, 32'h10, er);
        wr(4'h0, 32'h99, er);
        chk("wr_ok_err", er, 0);
        repeat (127) @(posedge pclk);
        #1 rd(4'h2, d, er);
        chk("up_cnt_128", d, 32'h20);
        repeat (6) @(posedge pclk);
        #1 rd(4'h2, d, er);
        chk("up_wrap_cnt", d, 32'h10);
        chk("up_irq_lag", irq_acc, 0);
        chk("up_irq", irq, 1);
        rchk("up_tsr", 4'h1, 32'h1);
        wr(4'h0, 32'h18, er);
        @(posedge pclk); #1;
        chk("ovf_ie_off_irq", irq, 0);
        rchk("ovf_kept", 4'h1, 32'h1);
        wr(4'h1, 32'h0, er);
        // down mode, div_sel=0, unf_ie
        wr(4'h3, 32'h5, er);
        wr(4'h4, 32'h8, er);
        wr(4'h2, 32'h5, er);
        wr(4'h0, 32'h103, er);
        rchk("dn_wrap_cnt", 4'h2, 32'h8);
        wr(4'h0, 32'h102, er);
        rchk("dn_frozen_cnt", 4'h2, 32'h5);
        rchk("dn_tsr", 4'h1, 32'h2);
        chk("dn_irq", irq, 1);
        wr(4'h1, 32'h0, er);
        chk("dn_irq_lag", irq, 1);
        @(posedge pclk); #1;
        chk("dn_irq_drop", irq, 0);
        rchk("dn_tsr_clr", 4'h1, 32'h0);
        // up-down mode
        wr(4'h3, 32'h2, er);
        wr(4'h4, 32'h4, er);
        wr(4'h2, 32'h2, er);
        wr(4'h0, 32'h5, er);
        for (int i = 0; i < 5; i++) begin
            @(posedge pclk); #1;
            peek(4'h2, d);
            chk($sformatf("ud_cnt%0d", i), d, ud_cnt[i]);
            peek(4'h1, d);
            chk($sformatf("ud_tsr%0d", i), d, ud_tsr[i]);
        end
        idle();
        wr(4'h0, 32'h4, er);
        wr(4'h1, 32'h0, er);
        // MIN >= MAX loads MIN without flags
        wr(4'h3, 32'h9, er);
        wr(4'h4, 32'h5, er);
        wr(4'h2, 32'h30, er);
        wr(4'h0, 32'h1, er);
        @(posedge pclk); #1;
        peek(4'h2, d);
        chk("minmax_cnt", d, 32'h9);
        @(posedge pclk); #1;
        peek(4'h2, d);
        chk("minmax_cnt2", d, 32'h9);
        peek(4'h1, d);
        chk("minmax_tsr", d, 32'h0);
        idle();
        wr(4'h0, 32'h0, er);
        // external ticks
        wr(4'h3, 32'h0, er);
        wr(4'h4, 32'hFFFF, er);
        wr(4'h2, 32'h100, er);
        wr(4'h0, 32'h41, er);
        for (int i = 0; i < 5; i++) begin
            ext_in = 1'b1;
            repeat (4) @(posedge pclk);
            #1 ext_in = 1'b0;
            repeat (4) @(posedge pclk);
            #1;
        end
        repeat (4) @(posedge pclk);
        #1 wr(4'h0, 32'h40, er);
        rchk("ext_cnt", 4'h2, 32'h105);
        for (int i = 0; i < 5; i++) begin
            ext_in = 1'b1;
            repeat (4) @(posedge pclk);
            #1 ext_in = 1'b0;
            repeat (4) @(posedge pclk);
            #1;
        end
        rchk("ext_en0_cnt", 4'h2, 32'h105);
        // bus errors
        rd(4'h7, d, er);
        chk("unmapped_err", er, 1);
        chk("unmapped_data", d, 32'h0);
        wr(4'h0, 32'h47, er);
        chk("mode11_err", er, 1);
        rchk("mode11_tcr", 4'h0, 32'h40);
        // CNT write beats tick, then reset mid-count
        wr(4'h3, 32'h22, er);
        wr(4'h4, 32'hFFFF, er);
        wr(4'h2, 32'h100, er);
        wr(4'h0, 32'h1, er);
        repeat (3) @(posedge pclk);
        #1 wr(4'h2, 32'h55, er);
        peek(4'h2, d);
        chk("cnt_wr_prio", d, 32'h55);
        @(posedge pclk); #1;
        peek(4'h2, d);
        chk("cnt_after_wr", d, 32'h56);
        idle();
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        chk("mid_rst_irq", irq, 0);
        rchk("mid_rst_tcr", 4'h0, 32'h0);
        rchk("mid_rst_tsr", 4'h1, 32'h0);
        rchk("mid_rst_cnt", 4'h2, 32'h0);
        rchk("mid_rst_min", 4'h3, 32'h0);
        rchk("mid_rst_max", 4'h4, 32'hFFFF);
        rchk("mid_rst_idle_cnt", 4'h2, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
